div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative divider serving the execute stage for DIV/DIVU.
- The execute stage drives the operands, start and annul, and stalls the pipeline (stallreq) while the divider is busy.
- The execute stage consumes the {remainder, quotient} result to write HI/LO.
- Radix-2 restoring division, one quotient bit per clock; a signed wrapper converts operands to magnitudes and corrects the result signs.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
signed_div_i  in  1  1 = signed DIV, 0 = unsigned DIVU
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
start_i  in  1  request division; held high by EX until ready_o seen
annul_i  in  1  abort current division (pipeline flush)
result_o  out  2*WIDTH  [63:32] remainder, [31:0] quotient
ready_o  out  1  result_o valid

Behaviour:
- All outputs registered. Reset (rst=1 at an edge): state FREE, ready_o=0, result_o=0, counter=0. Reset applies in any state, including mid-division; no partial result is ever presented.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0: latch signed_div_i and the operand signs.
    - opdata2_i==0: next state BYZERO.
    - Otherwise: latch magnitudes, counter=0, next state ON. Magnitude is two's-complement negation when signed_div_i=1 and bit31=1, else the raw value.
  - start_i=0 or annul_i=1: stay FREE. ready_o=0, result_o=0.
- BYZERO: next edge goes to END with quotient=0, remainder=0 (no exception raised here).
- ON:
  - annul_i=1: go to FREE immediately; ready_o stays 0; partial state is discarded.
  - Otherwise, while counter<32, perform one restoring step per edge:
    - shift {rem, quo} left 1, bringing in the next dividend bit MSB-first;
    - if rem>=divisor magnitude: subtract and set quotient bit to 1, else set it to 0;
    - counter+1.
  - At counter==32 (one extra edge): apply sign fix and go to END.
    - Quotient is negated iff signed and the operand signs differ.
    - Remainder is negated iff signed and the dividend is negative (remainder takes the dividend's sign).
    - Load result_o, set ready_o=1, counter=0.
- Latency: the start edge is E0. Iterations occur on E1..E32; finalize and ready_o=1 occur after E33. BYZERO gives ready_o=1 after E1.
- END:
  - ready_o=1 and result_o is held.
  - start_i=0: next edge goes to FREE, with ready_o=0 and result_o=0.
  - start_i=1: stay in END; the divider must not retrigger on the same request.
  - annul_i in END is ignored; EX drops start_i on flush.
- Operand inputs may change after E0; only latched values are used.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no flag).
- Simultaneous start_i and annul_i in FREE: annul wins, stay FREE.
- Arithmetic uses a 33-bit partial remainder so the compare/subtract never overflows.

Test Plan:
- Unsigned 100 / 7 (start held), sign 0 -> ready_o first high after E33; result_o = 0x00000002_0000000E; ready_o drops and result_o returns to 0 one cycle after start_i deasserts.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD. Also signed 7 / -2 -> 0x00000001_FFFFFFFD.
- Divisor 0 (opdata1=0x1234, start=1) -> ready_o after E1; result_o = 0. Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000 after E33, no hang.
- Annul at E10 -> FREE and ready_o never asserts. A new start of 50/5 two cycles later -> 0x00000000_0000000A with full 33-edge latency.
- rst=1 at E15 of an active division -> next cycle ready_o=0, result_o=0, state FREE. A following 9/4 yields 0x00000001_00000002.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Signed operands are divided as magnitudes; result signs are fixed on the finalize edge.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [1:0] S_FREE   = 2'b00;
    localparam logic [1:0] S_BYZERO = 2'b01;
    localparam logic [1:0] S_ON     = 2'b10;
    localparam logic [1:0] S_END    = 2'b11;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             sgn, neg1, neg2;
    logic [WIDTH-1:0] dvd, dvs, rem, mag1, mag2, rem_next, quo_fix, rem_fix;
    logic [WIDTH:0]   shifted, diff;

    // dvd holds the unconsumed dividend bits in its top and the quotient bits shifted in at the bottom
    always_comb begin
        mag1     = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2     = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted  = {rem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_fix  = (sgn && (neg1 ^ neg2)) ? -dvd : dvd;
        rem_fix  = (sgn && neg1) ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            sgn      <= 1'b0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: if (start_i && !annul_i) begin
                    sgn   <= signed_div_i;
                    neg1  <= opdata1_i[WIDTH-1];
                    neg2  <= opdata2_i[WIDTH-1];
                    dvd   <= mag1;
                    dvs   <= mag2;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
                S_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= S_END;
                end
                S_ON: if (annul_i) begin
                    state <= S_FREE;
                end else if (cnt != LAST) begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt + 1'b1;
                end else begin
                    result_o <= {rem_fix, quo_fix};
                    ready_o  <= 1'b1;
                    cnt      <= '0;
                    state    <= S_END;
                end
                S_END: if (!start_i) begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    state    <= S_FREE;
                end
                default: state <= S_FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst, signed_div_i, start_i, annul_i, ready_o;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;
    int          total = 0, bad = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    // Starts a division at the next edge (E0), scrambles operands afterwards, waits for ready_o.
    // lat counts edges after E0 until ready_o is seen; -1 if the bound expires. start_i stays high.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        signed_div_i = sd; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk); #1;
        opdata1_i = $urandom; opdata2_i = $urandom;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (ready_o) begin lat = i; break; end
        end
        res = result_o;
    endtask

    task automatic release_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        total++; if (result_o !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] r; int lat;
        run_div(1'b0, 32'd100, 32'd7, r, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
        total++; if (r !== 64'h00000002_0000000E) begin bad++; $display("FAIL u100_7_result got=%h exp=%h", r, 64'h00000002_0000000E); end
        @(posedge clk); #1;
        total++; if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
            bad++; $display("FAIL end_hold got=%b/%h exp=1/%h", ready_o, result_o, 64'h00000002_0000000E); end
        release_start();
        total++; if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++; $display("FAIL end_release got=%b/%h exp=0/0", ready_o, result_o); end
    endtask

    task automatic test_signed();
        logic [63:0] r; int lat;
        run_div(1'b1, 32'hFFFFFFF9, 32'h2, r, lat);
        release_start();
        total++; if (r !== 64'hFFFFFFFF_FFFFFFFD || lat !== 33) begin
            bad++; $display("FAIL s_m7_2 got=%h/%0d exp=%h/33", r, lat, 64'hFFFFFFFF_FFFFFFFD); end
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, r, lat);
        release_start();
        total++; if (r !== 64'h00000001_FFFFFFFD) begin
            bad++; $display("FAIL s_7_m2 got=%h exp=%h", r, 64'h00000001_FFFFFFFD); end
    endtask

    task automatic test_div_zero();
        logic [63:0] r; int lat;
        run_div(1'b0, 32'h1234, 32'h0, r, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL byzero_latency got=%0d exp=1", lat); end
        total++; if (r !== 64'h0) begin bad++; $display("FAIL byzero_result got=%h exp=0", r); end
        release_start();
        run_div(1'b0, 32'hFFFFFFFF, 32'h1, r, lat);
        release_start();
        total++; if (r !== 64'h00000000_FFFFFFFF || lat !== 33) begin
            bad++; $display("FAIL u_max_1 got=%h/%0d exp=%h/33", r, lat, 64'h00000000_FFFFFFFF); end
    endtask

    task automatic test_overflow();
        logic [63:0] r; int lat;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, r, lat);
        release_start();
        total++; if (r !== 64'h00000000_80000000 || lat !== 33) begin
            bad++; $display("FAIL s_overflow got=%h/%0d exp=%h/33", r, lat, 64'h00000000_80000000); end
    endtask

    task automatic test_annul();
        logic [63:0] r; int lat; logic seen;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL annul_no_ready got=%b exp=0", seen); end
        run_div(1'b0, 32'd50, 32'd5, r, lat);
        release_start();
        total++; if (r !== 64'h00000000_0000000A || lat !== 33) begin
            bad++; $display("FAIL after_annul got=%h/%0d exp=%h/33", r, lat, 64'h00000000_0000000A); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; int lat;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            bad++; $display("FAIL mid_reset got=%b/%h exp=0/0", ready_o, result_o); end
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        run_div(1'b0, 32'd9, 32'd4, r, lat);
        release_start();
        total++; if (r !== 64'h00000001_00000002 || lat !== 33) begin
            bad++; $display("FAIL after_reset got=%h/%0d exp=%h/33", r, lat, 64'h00000001_00000002); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; int lat; logic seen;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL start_annul_free got=%b exp=0", seen); end
        run_div(1'b1, 32'd20, 32'd6, r, lat);
        release_start();
        total++; if (r !== 64'h00000002_00000003 || lat !== 33) begin
            bad++; $display("FAIL s_20_6 got=%h/%0d exp=%h/33", r, lat, 64'h00000002_00000003); end
        run_div(1'b0, 32'hFFFFFFFF, 32'h00010000, r, lat);
        release_start();
        total++; if (r !== 64'h0000FFFF_0000FFFF || lat !== 33) begin
            bad++; $display("FAIL u_b2b got=%h/%0d exp=%h/33", r, lat, 64'h0000FFFF_0000FFFF); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
